mul_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It consumes the two source operands read from the register file (rs/rt data) and executes MULT, MULTU, DIV and DIVU over multiple cycles. It supplies HI or LO to the writeback path for MFHI/MFLO. While an operation is in flight, busy stalls the issuing pipeline.

---
 rtl/mul_div_unit_pkg.sv | 17 +
 rtl/mdu_iter_step.sv | 32 +++
 rtl/mul_div_unit.sv | 128 ++++++++++++
 tb/tb_mul_div_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mul_div_unit_pkg;
   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_e;
endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: LSB-first shift-add multiply or restoring divide step.
// Multiply keeps {acc,lo} as the shifting product; divide keeps acc=remainder, lo=dividend/quotient.
module mdu_iter_step import mul_div_unit_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_lo
);
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_rem;
   logic             w_ge;

   assign w_sum   = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_b} : '0);
   assign w_shift = {i_acc, i_lo[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, i_b});
   // When the subtract succeeds the difference is below the divisor, so WIDTH bits suffice.
   assign w_rem   = w_shift[WIDTH-1:0] - i_b;

   always_comb begin
      o_acc = w_sum[WIDTH:1];
      o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};
      if (i_is_div) begin
         o_acc = w_ge ? w_rem : w_shift[WIDTH-1:0];
         o_lo  = {i_lo[WIDTH-2:0], w_ge};
      end
   end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; start-to-done is WIDTH+1 edges.
// busy stalls the issuer; start/mthi/mtlo while busy are dropped.
module mul_div_unit import mul_div_unit_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             btn,
   input  logic             Rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdat,
   input  logic             rd_hi,
   output logic [WIDTH-1:0] rdat,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           r_state, w_next_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc, r_shf, r_opb, r_hi, r_lo;
   logic             r_is_div, r_neg_res, r_neg_rem, r_dbz, r_done, r_dbz_out;

   logic             w_sign_a, w_sign_b;
   logic [WIDTH-1:0] w_mag_a, w_mag_b, w_step_acc, w_step_lo, w_fix_hi, w_fix_lo;
   logic [2*WIDTH-1:0] w_prod_neg;

   assign w_sign_a   = ~op[0] & opA[WIDTH-1];
   assign w_sign_b   = ~op[0] & opB[WIDTH-1];
   assign w_mag_a    = w_sign_a ? -opA : opA;
   assign w_mag_b    = w_sign_b ? -opB : opB;
   assign w_prod_neg = -{r_acc, r_shf};

   mdu_iter_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_lo     (r_shf),
      .i_b      (r_opb),
      .o_acc    (w_step_acc),
      .o_lo     (w_step_lo)
   );

   always_ff @(posedge btn or posedge Rst) begin
      if (Rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE: if (start) w_next_state = ST_CALC;
         ST_CALC: if (r_cnt == LAST) w_next_state = ST_FIX;
         ST_FIX:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Divide-by-zero leaves the raw iteration result: all-ones quotient, dividend in acc.
   always_comb begin
      w_fix_hi = r_acc;
      w_fix_lo = r_shf;
      if (!r_is_div) begin
         if (r_neg_res) {w_fix_hi, w_fix_lo} = w_prod_neg;
      end else if (!r_dbz) begin
         if (r_neg_res) w_fix_lo = -r_shf;
         if (r_neg_rem) w_fix_hi = -r_acc;
      end
   end

   always_ff @(posedge btn or posedge Rst) begin
      if (Rst) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_shf     <= '0;
         r_opb     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dbz     <= 1'b0;
         r_done    <= 1'b0;
         r_dbz_out <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_dbz_out <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cnt     <= '0;
                  r_acc     <= '0;
                  r_shf     <= w_mag_a;
                  r_opb     <= w_mag_b;
                  r_is_div  <= op[1];
                  r_neg_res <= w_sign_a ^ w_sign_b;
                  r_neg_rem <= w_sign_a;
                  r_dbz     <= op[1] && (opB == '0);
               end else begin
                  if (mthi) r_hi <= wdat;
                  if (mtlo) r_lo <= wdat;
               end
            end
            ST_CALC: begin
               r_acc <= w_step_acc;
               r_shf <= w_step_lo;
               r_cnt <= r_cnt + 1'b1;
            end
            ST_FIX: begin
               r_hi      <= w_fix_hi;
               r_lo      <= w_fix_lo;
               r_done    <= 1'b1;
               r_dbz_out <= r_dbz;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign div_by_zero = r_dbz_out;
   assign rdat        = rd_hi ? r_hi : r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a cycle-level arithmetic model and per-cycle compare.
module tb_mul_div_unit;
   logic        btn = 1'b0, Rst = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0, rd_hi = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] opA = '0, opB = '0, wdat = '0;
   logic [31:0] rdat;
   logic        busy, done, div_by_zero;

   int total = 0;
   int bad   = 0;

   // model state
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
   int          m_cnt = 0;

   // sampled DUT outputs
   logic [31:0] s_hi = '0, s_lo = '0;
   logic        s_busy = 1'b0, s_done = 1'b0, s_dbz = 1'b0;

   mul_div_unit #(.WIDTH(32)) dut (
      .btn(btn), .Rst(Rst), .start(start), .op(op), .opA(opA), .opB(opB),
      .mthi(mthi), .mtlo(mtlo), .wdat(wdat), .rd_hi(rd_hi), .rdat(rdat),
      .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 btn = ~btn;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [64:0] model_res(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     p;
      logic [31:0]     mag;
      logic [64:0]     res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      mag = a[31] ? -a : a;
      res = '0;
      case (f_op)
         2'b00: begin p = sa * sb; res = {1'b0, p}; end
         2'b01: begin p = ua * ub; res = {1'b0, p}; end
         2'b10: begin
            if (b == 32'd0) res = {1'b1, mag, 32'hFFFFFFFF};
            else begin
               q = sa / sb; r = sa % sb;
               res = {1'b0, r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {1'b1, a, 32'hFFFFFFFF};
            else begin
               uq = ua / ub; ur = ua % ub;
               res = {1'b0, ur[31:0], uq[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   always @(posedge btn or posedge Rst) begin : model
      logic [64:0] r;
      if (Rst) begin
         m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; m_cnt = 0;
      end else begin
         m_done = 1'b0;
         m_dbz  = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
            end
         end else if (start) begin
            r = model_res(op, opA, opB);
            {p_dbz, p_hi, p_lo} = r;
            m_cnt = 33;
         end else begin
            if (mthi) m_hi = wdat;
            if (mtlo) m_lo = wdat;
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge btn);
         rd_hi = 1'b1;
         #1 s_hi = rdat;
         rd_hi = 1'b0;
         #1 s_lo = rdat;
         s_busy = busy; s_done = done; s_dbz = div_by_zero;
         check("cyc_hi",   s_hi, m_hi);
         check("cyc_lo",   s_lo, m_lo);
         check("cyc_busy", 32'(s_busy), 32'(m_cnt != 0));
         check("cyc_done", 32'(s_done), 32'(m_done));
         check("cyc_dbz",  32'(s_dbz),  32'(m_dbz));
      end
   end

   // inj: 0 none, 1 extra start + mthi while busy, 2 mthi on the start edge
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dbz, input int inj);
      int  lat;
      bit  seen;
      op = o; opA = a; opB = b; start = 1'b1;
      if (inj == 2) begin mthi = 1'b1; wdat = 32'h0000BEEF; end
      seen = 0;
      lat  = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge btn);
         #3;
         if (i == 0) begin
            start = 1'b0;
            mthi  = 1'b0;
            check("busy_after_start", 32'(s_busy), 32'd1);
            if (inj == 2) check("mthi_dropped_on_start", s_hi, 32'h00000001);
         end
         if (inj == 1) begin
            if (i == 4) begin start = 1'b1; op = 2'b01; opA = 32'd2; opB = 32'd3; end
            if (i == 5) start = 1'b0;
            if (i == 7) begin mthi = 1'b1; wdat = 32'h0000DEAD; end
            if (i == 8) mthi = 1'b0;
         end
         if (i == 32) check("busy_last_step", 32'(s_busy), 32'd1);
         if (s_done) begin seen = 1; lat = i; end
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL done_timeout: no done within 100 cycles, required after 33");
      end else begin
         check("latency",  32'(lat), 32'd33);
         check("res_hi",   s_hi, exp_hi);
         check("res_lo",   s_lo, exp_lo);
         check("res_dbz",  32'(s_dbz), 32'(exp_dbz));
         check("busy_done", 32'(s_busy), 32'd0);
      end
   endtask

   initial begin : driver
      bit saw_done;
      #1 Rst = 1'b1;
      repeat (2) @(negedge btn);
      #3 Rst = 1'b0;
      @(negedge btn);
      #3;
      check("rst_hi",   s_hi, 32'd0);
      check("rst_lo",   s_lo, 32'd0);
      check("rst_busy", 32'(s_busy), 32'd0);
      check("rst_done", 32'(s_done), 32'd0);

      run_op(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
      run_op(2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 0);
      @(negedge btn);
      #3;
      check("dbz_one_cycle", 32'(s_dbz), 32'd0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);
      run_op(2'b11, 32'd10,       32'd3,        32'h00000001, 32'h00000003, 1'b0, 1);

      @(negedge btn);
      #3;
      mtlo = 1'b1; wdat = 32'h12345678;
      @(negedge btn);
      #3;
      mtlo = 1'b0;
      check("mtlo_rdat", s_lo, 32'h12345678);
      run_op(2'b01, 32'd5, 32'd6, 32'h00000000, 32'd30, 1'b0, 2);

      op = 2'b01; opA = 32'd5; opB = 32'd5; start = 1'b1;
      @(posedge btn);
      #1 start = 1'b0;
      repeat (10) @(posedge btn);
      #1 Rst = 1'b1;
      @(negedge btn);
      #3;
      check("abort_busy", 32'(s_busy), 32'd0);
      check("abort_hi",   s_hi, 32'd0);
      check("abort_lo",   s_lo, 32'd0);
      Rst = 1'b0;
      saw_done = 0;
      repeat (40) begin
         @(negedge btn);
         #3;
         if (s_done) saw_done = 1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      run_op(2'b01, 32'd5, 32'd5, 32'h00000000, 32'd25, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
